// File: rtl/datapath_md_pkg.sv
// Shared encodings for the multicycle datapath with iterative multiply/divide.
package datapath_md_pkg;

  localparam logic [1:0] MDOP_MULT  = 2'd0;
  localparam logic [1:0] MDOP_MULTU = 2'd1;
  localparam logic [1:0] MDOP_DIV   = 2'd2;
  localparam logic [1:0] MDOP_DIVU  = 2'd3;

  localparam logic [1:0] MTR_ALUOUT = 2'd0;
  localparam logic [1:0] MTR_DATA   = 2'd1;
  localparam logic [1:0] MTR_HI     = 2'd2;
  localparam logic [1:0] MTR_LO     = 2'd3;

  // Jump target = {pc[W-1:JT_PC_LSB], instr[JT_IDX_W-1:0], 2'b00}
  localparam int JT_PC_LSB = 28;
  localparam int JT_IDX_W  = 26;

  typedef enum logic [1:0] {IDLE, NORM, ITER, DONE} md_state_e;

  function automatic logic mdop_signed(input logic [1:0] op);
    return (op == MDOP_MULT) || (op == MDOP_DIV);
  endfunction

  function automatic logic mdop_mult(input logic [1:0] op);
    return (op == MDOP_MULT) || (op == MDOP_MULTU);
  endfunction

endpackage

// File: rtl/datapath_md_mdu_iter.sv
// Radix-2 iterative multiply/divide on operand magnitudes with a final sign fix.
module mdu_iter
  import datapath_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 2);

  md_state_e        r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_opa, r_opb, r_p, r_q, r_m, r_hi, r_lo;

  logic             w_sa, w_sb, w_neg, w_ge;
  logic [WIDTH:0]   w_sum, w_rsh;
  logic [WIDTH-1:0] w_diff, w_p_nxt, w_q_nxt, w_hi_res, w_lo_res;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;

  assign w_sa  = mdop_signed(r_op) & r_opa[WIDTH-1];
  assign w_sb  = mdop_signed(r_op) & r_opb[WIDTH-1];
  assign w_neg = w_sa ^ w_sb;

  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;

  // DONE performs the last iteration itself, so busy spans NORM + WIDTH steps.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = NORM;
      NORM:    w_state_nxt = ITER;
      ITER:    if (r_cnt == LAST_ITER) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // One step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    w_sum  = {1'b0, r_p} + (r_q[0] ? {1'b0, r_m} : '0);
    w_rsh  = {r_p, r_q[WIDTH-1]};
    w_ge   = (w_rsh >= {1'b0, r_m});
    w_diff = w_rsh[WIDTH-1:0] - r_m;
    if (mdop_mult(r_op)) begin
      w_p_nxt = w_sum[WIDTH:1];
      w_q_nxt = {w_sum[0], r_q[WIDTH-1:1]};
    end else begin
      w_p_nxt = w_ge ? w_diff : w_rsh[WIDTH-1:0];
      w_q_nxt = {r_q[WIDTH-2:0], w_ge};
    end
  end

  assign w_prod   = {w_p_nxt, w_q_nxt};
  assign w_prod_s = w_neg ? -w_prod : w_prod;

  always_comb begin
    w_hi_res = w_prod_s[2*WIDTH-1:WIDTH];
    w_lo_res = w_prod_s[WIDTH-1:0];
    if (!mdop_mult(r_op)) begin
      if (r_opb == '0) begin
        w_hi_res = r_opa;
        w_lo_res = '1;
      end else begin
        w_hi_res = w_sa  ? -w_p_nxt : w_p_nxt;
        w_lo_res = w_neg ? -w_q_nxt : w_q_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_opa <= '0;
      r_opb <= '0;
      r_p   <= '0;
      r_q   <= '0;
      r_m   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_op  <= i_op;
          r_opa <= i_a;
          r_opb <= i_b;
        end
        NORM: begin
          r_p   <= '0;
          r_q   <= w_sa ? -r_opa : r_opa;
          r_m   <= w_sb ? -r_opb : r_opb;
          r_cnt <= '0;
        end
        ITER: begin
          r_p   <= w_p_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + CW'(1);
        end
        DONE: begin
          r_hi <= w_hi_res;
          r_lo <= w_lo_res;
        end
        default: ;
      endcase
    end

  assign o_busy = (r_state != IDLE);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
endmodule

// File: rtl/datapath_md_parts.sv
// Reusable datapath parts: flops, muxes, register file, sign-extend, shift, ALU.
module flopr #(parameter int W = 32) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) o_q <= '0;
    else       o_q <= i_d;
endmodule

module flopenr #(parameter int W = 32) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  always_ff @(posedge clk or posedge reset)
    if (reset)     o_q <= '0;
    else if (i_en) o_q <= i_d;
endmodule

module mux2 #(parameter int W = 32) (
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  input  logic         i_s,
  output logic [W-1:0] o_y
);
  assign o_y = i_s ? i_d1 : i_d0;
endmodule

module mux4 #(parameter int W = 32) (
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  input  logic [W-1:0] i_d2,
  input  logic [W-1:0] i_d3,
  input  logic [1:0]   i_s,
  output logic [W-1:0] o_y
);
  always_comb begin
    o_y = i_d0;
    case (i_s)
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      2'd3:    o_y = i_d3;
      default: o_y = i_d0;
    endcase
  end
endmodule

// No reset on the array; register 0 is forced to zero on read.
module regfile #(parameter int W = 32) (
  input  logic         clk,
  input  logic         i_we,
  input  logic [4:0]   i_ra1,
  input  logic [4:0]   i_ra2,
  input  logic [4:0]   i_wa,
  input  logic [W-1:0] i_wd,
  output logic [W-1:0] o_rd1,
  output logic [W-1:0] o_rd2
);
  logic [W-1:0] r_mem [32];

  always_ff @(posedge clk)
    if (i_we) r_mem[i_wa] <= i_wd;

  assign o_rd1 = (i_ra1 == 5'd0) ? '0 : r_mem[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? '0 : r_mem[i_ra2];
endmodule

module signext #(parameter int W = 32) (
  input  logic [15:0]  i_a,
  output logic [W-1:0] o_y
);
  assign o_y = {{(W-16){i_a[15]}}, i_a};
endmodule

module sl2 #(parameter int W = 32) (
  input  logic [W-1:0] i_a,
  output logic [W-1:0] o_y
);
  assign o_y = {i_a[W-3:0], 2'b00};
endmodule

// f[2] inverts b (subtract); f[1:0]: and, or, add/sub, slt.
module alu #(parameter int W = 32) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [2:0]   i_f,
  output logic [W-1:0] o_y,
  output logic         o_zero
);
  logic [W-1:0] w_bb, w_sum;

  assign w_bb  = i_f[2] ? ~i_b : i_b;
  assign w_sum = i_a + w_bb + {{(W-1){1'b0}}, i_f[2]};

  always_comb begin
    o_y = '0;
    case (i_f[1:0])
      2'd0:    o_y = i_a & w_bb;
      2'd1:    o_y = i_a | w_bb;
      2'd2:    o_y = w_sum;
      default: o_y = {{(W-1){1'b0}}, w_sum[W-1]};
    endcase
  end

  assign o_zero = (o_y == '0);
endmodule

// File: rtl/datapath_md.sv
// Multicycle MIPS-style datapath with optional iterative multiply/divide unit.
module datapath_md
  import datapath_md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MD_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcen,
  input  logic             irwrite,
  input  logic             regwrite,
  input  logic             alusrca,
  input  logic             iord,
  input  logic             regdst,
  input  logic [1:0]       memtoreg,
  input  logic [1:0]       alusrcb,
  input  logic [1:0]       pcsrc,
  input  logic [2:0]       alucontrol,
  input  logic             mdstart,
  input  logic [1:0]       mdop,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic             zero,
  output logic             mdbusy,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] readdata
);
  localparam logic [WIDTH-1:0] PC_INC = WIDTH'(4);

  logic [WIDTH-1:0] r_pc, r_instr, r_data, r_a, r_b, r_aluout;
  logic [WIDTH-1:0] w_pcnext, w_rd1, w_rd2, w_wd, w_srca, w_srcb, w_aluresult;
  logic [WIDTH-1:0] w_signimm, w_signimmsh, w_jta, w_hi, w_lo;
  logic [4:0]       w_wa;

  flopenr #(WIDTH) u_pcreg (.clk(clk), .reset(reset), .i_en(pcen),    .i_d(w_pcnext),    .o_q(r_pc));
  flopenr #(WIDTH) u_ir    (.clk(clk), .reset(reset), .i_en(irwrite), .i_d(readdata),    .o_q(r_instr));
  flopr   #(WIDTH) u_data  (.clk(clk), .reset(reset), .i_d(readdata),    .o_q(r_data));
  flopr   #(WIDTH) u_areg  (.clk(clk), .reset(reset), .i_d(w_rd1),       .o_q(r_a));
  flopr   #(WIDTH) u_breg  (.clk(clk), .reset(reset), .i_d(w_rd2),       .o_q(r_b));
  flopr   #(WIDTH) u_alur  (.clk(clk), .reset(reset), .i_d(w_aluresult), .o_q(r_aluout));

  mux2 #(WIDTH) u_adrmux (.i_d0(r_pc), .i_d1(r_aluout), .i_s(iord), .o_y(adr));
  mux2 #(5)     u_wamux  (.i_d0(r_instr[20:16]), .i_d1(r_instr[15:11]), .i_s(regdst), .o_y(w_wa));

  always_comb begin
    w_wd = r_aluout;
    case (memtoreg)
      MTR_ALUOUT: w_wd = r_aluout;
      MTR_DATA:   w_wd = r_data;
      MTR_HI:     w_wd = w_hi;
      MTR_LO:     w_wd = w_lo;
      default:    w_wd = r_aluout;
    endcase
  end

  regfile #(WIDTH) u_rf (
    .clk(clk), .i_we(regwrite), .i_ra1(r_instr[25:21]), .i_ra2(r_instr[20:16]),
    .i_wa(w_wa), .i_wd(w_wd), .o_rd1(w_rd1), .o_rd2(w_rd2)
  );

  signext #(WIDTH) u_se  (.i_a(r_instr[15:0]), .o_y(w_signimm));
  sl2     #(WIDTH) u_sl2 (.i_a(w_signimm),     .o_y(w_signimmsh));

  mux2 #(WIDTH) u_srcamux (.i_d0(r_pc), .i_d1(r_a), .i_s(alusrca), .o_y(w_srca));
  mux4 #(WIDTH) u_srcbmux (
    .i_d0(r_b), .i_d1(PC_INC), .i_d2(w_signimm), .i_d3(w_signimmsh), .i_s(alusrcb), .o_y(w_srcb)
  );

  alu #(WIDTH) u_alu (.i_a(w_srca), .i_b(w_srcb), .i_f(alucontrol), .o_y(w_aluresult), .o_zero(zero));

  assign w_jta = {r_pc[WIDTH-1:JT_PC_LSB], r_instr[JT_IDX_W-1:0], 2'b00};

  mux4 #(WIDTH) u_pcmux (
    .i_d0(w_aluresult), .i_d1(r_aluout), .i_d2(w_jta), .i_d3(w_aluresult), .i_s(pcsrc), .o_y(w_pcnext)
  );

  generate
    if (MD_EN != 0) begin : g_md
      mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk(clk), .reset(reset), .i_start(mdstart), .i_op(mdop), .i_a(r_a), .i_b(r_b),
        .o_busy(mdbusy), .o_hi(w_hi), .o_lo(w_lo)
      );
    end else begin : g_nomd
      assign mdbusy = 1'b0;
      assign w_hi   = '0;
      assign w_lo   = '0;
    end
  endgenerate

  assign op        = r_instr[31:26];
  assign funct     = r_instr[5:0];
  assign writedata = r_b;
endmodule

// File: doc/datapath_md.md
DATAPATH_MD -- requirements
Module: datapath_md

Interface
REQ-001 The module SHALL declare parameters, one per line:
- WIDTH, default 32, datapath/register width; legal values are 32 or 64.
- MD_EN, default 1, instantiates the multiply/divide unit when 1.
REQ-002 The module SHALL declare ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- pcen, irwrite, regwrite  in  1 each  PC, instruction-register and register-file write enables.
- alusrca, iord, regdst  in  1 each  source selects.
- memtoreg  in  2  writeback select: 0 aluout, 1 data, 2 hi, 3 lo.
- alusrcb, pcsrc  in  2 each  selects.
- alucontrol  in  3  ALU op.
- mdstart  in  1  start multiply/divide.
- mdop  in  2  operation: 0 mult, 1 multu, 2 div, 3 divu.
- op, funct  out  6 each  instr[31:26], instr[5:0].
- zero  out  1  ALU result equals 0.
- mdbusy  out  1  multiply/divide in progress.
- adr, writedata  out  WIDTH each  memory address and store data.
- readdata  in  WIDTH  memory read data.

Function
REQ-003 PC, IR, data, A, B and ALUOut registers SHALL be WIDTH-bit, unconditional (ALUOut, A, B, data) or enabled (PC by pcen, IR by irwrite) on the rising edge of clk.
REQ-004 adr SHALL be pc when iord=0, else aluout.
REQ-005 srca SHALL be pc or A; srcb SHALL be B, constant 4, sign-extended imm, or sign-extended imm shifted left 2, per alusrcb 0..3.
REQ-006 pcnext SHALL be aluresult, aluout, or the jump target {pc[WIDTH-1:28], instr[25:0], 2'b00}, per pcsrc 0..2; pcsrc=3 SHALL select aluresult.
REQ-007 Register 0 SHALL read as zero regardless of writes; reads SHALL be combinational; writes SHALL occur on the clk edge when regwrite=1.
REQ-008 A mdstart pulse SHALL be accepted only when mdbusy=0; operands SHALL be A (rs) and B (rt) captured on the accepting edge.
REQ-009 mdbusy SHALL rise the cycle after acceptance and stay high for exactly WIDTH+1 cycles: 1 sign-normalise cycle plus WIDTH radix-2 iterations; hi/lo SHALL update on the edge where mdbusy falls.
REQ-010 mdstart asserted while mdbusy=1, including the final busy cycle, SHALL be ignored without side effects.
REQ-011 mult/multu SHALL produce a 2*WIDTH-bit product, with hi = upper half and lo = lower half.
REQ-012 div/divu SHALL produce lo = quotient truncated toward zero and hi = remainder with the sign of the dividend.
REQ-013 Divide by zero SHALL give lo = all ones and hi = dividend, with the same latency.
REQ-014 Signed div of most-negative by -1 SHALL give lo = most-negative and hi = 0.
REQ-015 memtoreg=2/3 while mdbusy=1 SHALL return the previous hi/lo values; stalling is the controller's duty.
REQ-016 With MD_EN=0: mdbusy SHALL be tied 0, hi/lo SHALL read 0, and mdstart SHALL be ignored.

Reset
REQ-017 While reset is high, all registers SHALL clear to 0 asynchronously: pc, instr, data, A, B, aluout, hi, lo and the MDU state.
REQ-018 After reset: adr=0, op=0, funct=0, mdbusy=0, writedata=0.
REQ-019 Reset during an MDU operation SHALL abort it; no partial result SHALL reach hi/lo.
REQ-020 The register file is not reset; its contents after reset are undefined.

Structure
REQ-021 A shared package SHALL hold the mdop encodings, the memtoreg encodings and the jump-target field constants.
REQ-022 The multiply/divide engine SHALL be one sub-module, mdu_iter, containing its FSM (IDLE, NORM, ITER, DONE) and an iteration counter of width clog2(WIDTH+1).
REQ-023 Existing flop, mux, regfile, signext, sl2 and alu parts SHALL be reused, parametrised to WIDTH.

Verification
REQ-024 Fetch: reset then pcen=1, irwrite=1, alusrcb=1, pcsrc=0, readdata=0x20080005 -> pc=4 and op=0x08 after one edge.
REQ-025 mult: A=0xFFFFFFFD (-3), B=7, mdop=0 -> mdbusy high for 33 cycles, then hi=0xFFFFFFFF and lo=0xFFFFFFEB.
REQ-026 divu: A=100, B=7 -> lo=14, hi=2. div: A=-7, B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-027 Divide by zero: A=0x1234, B=0, mdop=3 -> lo=0xFFFFFFFF, hi=0x1234 after 33 busy cycles.
REQ-028 Second mdstart on the last busy cycle -> ignored, hi/lo unchanged from the first result; reset at busy cycle 10 -> mdbusy=0 and hi=lo=0 immediately.
REQ-029 Write register 0 with 0xDEAD -> reads 0; WIDTH=64 run of the mult scenario -> hi=all ones, lo=-21, 65 busy cycles.
